// File: rtl/register_bank_mem_r3_pkg.sv
// register_bank_mem_r3_pkg: shared fill-FSM encoding and address-width helper
package register_bank_mem_r3_pkg;

   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fill_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/reg_bank_fill_ctrl.sv
// reg_bank_fill_ctrl: fill sequencer holding state, word pointer and latched pattern
module reg_bank_fill_ctrl
   import register_bank_mem_r3_pkg::*;
#(
   parameter int NrOfBits = 8,
   parameter int Depth    = 16,
   parameter int AddrBits = clog2(Depth)
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                step,
   input  logic                fill,
   input  logic [NrOfBits-1:0] d,
   output logic                busy,
   output logic [AddrBits-1:0] ptr,
   output logic [NrOfBits-1:0] pattern
);

   localparam logic [AddrBits-1:0] Last = AddrBits'(Depth - 1);

   fill_state_t         state, state_nx;
   logic [AddrBits-1:0] ptr_nx;
   logic [NrOfBits-1:0] pattern_nx;
   logic                start, adv;

   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         state   <= IDLE;
         ptr     <= '0;
         pattern <= '0;
      end else begin
         state   <= state_nx;
         ptr     <= ptr_nx;
         pattern <= pattern_nx;
      end

   // Fill is only sampled in IDLE, so a request during a fill cannot restart it
   always_comb begin
      start      = step && state == IDLE && fill;
      adv        = step && state == FILL;
      state_nx   = start ? FILL : (adv && ptr == Last) ? IDLE : state;
      ptr_nx     = start ? '0 : adv ? ptr + AddrBits'(1) : ptr;
      pattern_nx = start ? d : pattern;
   end

   assign busy = state == FILL;

endmodule

// File: rtl/register_bank_mem_r3.sv
// register_bank_mem_r3: register-bank memory with fill sequencer, registered read and tri-state outputs
module register_bank_mem_r3
   import register_bank_mem_r3_pkg::*;
#(
   parameter int NrOfBits    = 8,
   parameter int Depth       = 16,
   parameter int AddrBits    = clog2(Depth),
   parameter int ActiveLevel = 1
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                ClockEnable,
   input  logic                Tick,
   input  logic                cs,
   input  logic                WrEn,
   input  logic [AddrBits-1:0] WrAddr,
   input  logic [NrOfBits-1:0] D,
   input  logic                RdEn,
   input  logic [AddrBits-1:0] RdAddr,
   input  logic                Fill,
   output logic [NrOfBits-1:0] Q,
   output logic                RdValid,
   output logic                Busy
);

   logic                clk_a;
   logic                step;
   logic                wr_ok, rd_ok;
   logic [AddrBits-1:0] ptr;
   logic [NrOfBits-1:0] pattern;
   logic [NrOfBits-1:0] q_reg;
   logic                rd_valid;
   logic [NrOfBits-1:0] mem [Depth];

   // ActiveLevel=0 moves every state update onto the falling edge
   assign clk_a = (ActiveLevel != 0) ? Clock : ~Clock;
   assign step  = ClockEnable & Tick;
   assign wr_ok = int'(WrAddr) < Depth;
   assign rd_ok = int'(RdAddr) < Depth;

   reg_bank_fill_ctrl #(
      .NrOfBits (NrOfBits),
      .Depth    (Depth),
      .AddrBits (AddrBits)
   ) u_fill (
      .Clock   (clk_a),
      .Reset   (Reset),
      .step    (step),
      .fill    (Fill),
      .d       (D),
      .busy    (Busy),
      .ptr     (ptr),
      .pattern (pattern)
   );

   // Non-blocking update of mem and q_reg gives read-first behaviour on collisions
   always_ff @(posedge clk_a or negedge Reset)
      if (!Reset) begin
         for (int i = 0; i < Depth; i++) mem[i] <= '0;
         q_reg    <= '0;
         rd_valid <= 1'b0;
      end else if (step) begin
         if (Busy) mem[ptr] <= pattern;
         else if (WrEn && !Fill && wr_ok) mem[WrAddr] <= D;
         if (RdEn) q_reg <= rd_ok ? mem[RdAddr] : '0;
         rd_valid <= RdEn;
      end

   assign Q       = cs ? 'z : q_reg;
   assign RdValid = cs ? 1'bz : rd_valid;

endmodule

// File: tb/tb_register_bank_mem_r3.sv
// tb_register_bank_mem_r3: directed checks of write/read, fill, stall, read-first, reset abort and chip select
module tb_register_bank_mem_r3;

   logic       Clock = 1'b0;
   logic       Reset, ClockEnable, Tick, cs, WrEn, RdEn, Fill;
   logic [3:0] WrAddr, RdAddr;
   logic [7:0] D;
   wire  [7:0] q_w;
   wire        rdv_w;
   logic       Busy;
   int         errors = 0;
   int         checks = 0;
   int         n;

   // undriven outputs float to the pull-ups, so a released bus reads all ones
   genvar g;
   for (g = 0; g < 8; g++) begin : g_pu
      pullup (q_w[g]);
   end
   pullup (rdv_w);

   register_bank_mem_r3 dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .ClockEnable (ClockEnable),
      .Tick        (Tick),
      .cs          (cs),
      .WrEn        (WrEn),
      .WrAddr      (WrAddr),
      .D           (D),
      .RdEn        (RdEn),
      .RdAddr      (RdAddr),
      .Fill        (Fill),
      .Q           (q_w),
      .RdValid     (rdv_w),
      .Busy        (Busy)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d_in);
      WrEn = 1'b1; WrAddr = a; D = d_in;
      step();
      WrEn = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      RdEn = 1'b1; RdAddr = a;
      step();
      RdEn = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b0; ClockEnable = 1'b1; Tick = 1'b1; cs = 1'b0;
      WrEn = 1'b0; RdEn = 1'b0; Fill = 1'b0;
      WrAddr = '0; RdAddr = '0; D = '0;
      #12;
      check("rst_q", q_w, 8'h00);
      check("rst_rdvalid", {7'b0, rdv_w}, 8'h00);
      check("rst_busy", {7'b0, Busy}, 8'h00);
      Reset = 1'b1;
      wr(4'd3, 8'hA5);
      rd(4'd3);
      check("rd3_q", q_w, 8'hA5);
      check("rd3_valid", {7'b0, rdv_w}, 8'h01);
      step();
      check("idle_valid", {7'b0, rdv_w}, 8'h00);
      check("idle_q_hold", q_w, 8'hA5);
      WrEn = 1'b1; WrAddr = 4'd7; D = 8'h11; RdEn = 1'b1; RdAddr = 4'd7;
      step();
      WrEn = 1'b0; RdEn = 1'b0;
      check("rdfirst_old", q_w, 8'h00);
      rd(4'd7);
      check("rdfirst_new", q_w, 8'h11);
      Tick = 1'b0; WrEn = 1'b1; WrAddr = 4'd3; D = 8'hFF; RdEn = 1'b1; RdAddr = 4'd3;
      repeat (5) step();
      check("stall_q", q_w, 8'h11);
      check("stall_valid", {7'b0, rdv_w}, 8'h01);
      check("stall_busy", {7'b0, Busy}, 8'h00);
      Tick = 1'b1; WrEn = 1'b0; RdEn = 1'b0;
      rd(4'd3);
      check("stall_mem", q_w, 8'hA5);
      D = 8'h3C; Fill = 1'b1;
      step();
      Fill = 1'b0;
      check("fill_busy", {7'b0, Busy}, 8'h01);
      WrEn = 1'b1; WrAddr = 4'd0; D = 8'h77;
      n = 0;
      for (int i = 0; i < 20 && Busy; i++) begin
         Fill = (i == 7);
         step();
         n++;
      end
      Fill = 1'b0; WrEn = 1'b0;
      check("fill_len", 8'(n), 8'd16);
      check("fill_done_busy", {7'b0, Busy}, 8'h00);
      for (int a = 0; a < 16; a++) begin
         rd(4'(a));
         check($sformatf("fill_word%0d", a), q_w, 8'h3C);
      end
      D = 8'h5A; Fill = 1'b1;
      step();
      Fill = 1'b0;
      repeat (9) step();
      check("abort_busy_pre", {7'b0, Busy}, 8'h01);
      #2 Reset = 1'b0;
      #1;
      check("abort_busy", {7'b0, Busy}, 8'h00);
      check("abort_q", q_w, 8'h00);
      Reset = 1'b1;
      for (int a = 0; a < 16; a++) begin
         rd(4'(a));
         check($sformatf("abort_word%0d", a), q_w, 8'h00);
      end
      check("abort_stays_idle", {7'b0, Busy}, 8'h00);
      wr(4'd5, 8'h42);
      cs = 1'b1; RdEn = 1'b1; RdAddr = 4'd5;
      step();
      RdEn = 1'b0;
      check("cs_q_z", q_w, 8'hFF);
      check("cs_valid_z", {7'b0, rdv_w}, 8'h01);
      check("cs_busy_driven", {7'b0, Busy}, 8'h00);
      cs = 1'b0;
      #1;
      check("cs_q_back", q_w, 8'h42);
      check("cs_valid_back", {7'b0, rdv_w}, 8'h01);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
